// File: rtl/load_store_unit.sv
// Load/store unit between execute and write-back: one op per transaction over a
// handshaked word-addressed data bus, with lane steering, load extension and error/timeout reporting.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_func,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    input  logic        mem_resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        wen_q, wen_d;
    logic [2:0]  func_q, func_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_req_valid_q, mem_req_valid_d;
    logic        mem_req_wen_q, mem_req_wen_d;
    logic [31:0] mem_req_addr_q, mem_req_addr_d;
    logic [31:0] mem_req_wdata_q, mem_req_wdata_d;
    logic [3:0]  mem_req_wmask_q, mem_req_wmask_d;

    logic        req_bad;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wmask;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [15:0] cnt_inc;
    logic        timeout_hit;

    always_comb begin
        req_bad = 1'b0;
        case (req_func)
            3'b011, 3'b110, 3'b111: req_bad = 1'b1;
            3'b001, 3'b101:         req_bad = req_addr[0];
            3'b010:                 req_bad = (req_addr[1:0] != 2'b00);
            default:                req_bad = 1'b0;
        endcase
        if (req_wen && req_func[2]) req_bad = 1'b1;
    end

    always_comb begin
        lane_wdata = req_wdata;
        lane_wmask = 4'b1111;
        case (req_func[1:0])
            2'b00: begin
                lane_wdata = {4{req_wdata[7:0]}};
                lane_wmask = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{req_wdata[15:0]}};
                lane_wmask = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                lane_wdata = req_wdata;
                lane_wmask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        shifted = mem_resp_rdata >> {off_q, 3'b000};
        case (func_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = shifted;
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            default: load_data = 32'b0;
        endcase
    end

    assign cnt_inc     = cnt_q + 16'd1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == 16'(TIMEOUT));

    always_comb begin
        state_d         = state_q;
        wen_d           = wen_q;
        func_d          = func_q;
        off_d           = off_q;
        cnt_d           = cnt_q;
        resp_valid_d    = resp_valid_q;
        resp_rdata_d    = resp_rdata_q;
        resp_err_d      = resp_err_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_wen_d   = mem_req_wen_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        mem_req_wmask_d = mem_req_wmask_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wen_d  = req_wen;
                    func_d = req_func;
                    off_d  = req_addr[1:0];
                    if (req_bad) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'b0;
                    end else begin
                        state_d         = S_REQ;
                        cnt_d           = 16'd0;
                        mem_req_valid_d = 1'b1;
                        mem_req_wen_d   = req_wen;
                        mem_req_addr_d  = {req_addr[31:2], 2'b00};
                        mem_req_wdata_d = lane_wdata;
                        mem_req_wmask_d = req_wen ? lane_wmask : 4'b0000;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                if (mem_req_ready) begin
                    state_d         = S_WAIT;
                    mem_req_valid_d = 1'b0;
                end
                // Timeout wins even over a same-cycle handshake; the late response is then ignored.
                if (timeout_hit) begin
                    state_d         = S_RESP;
                    mem_req_valid_d = 1'b0;
                    resp_valid_d    = 1'b1;
                    resp_err_d      = 1'b1;
                    resp_rdata_d    = 32'b0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (mem_resp_valid) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = mem_resp_err;
                    resp_rdata_d = (wen_q || mem_resp_err) ? 32'b0 : load_data;
                end else if (timeout_hit) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'b0;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'b0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            wen_q           <= 1'b0;
            func_q          <= 3'b0;
            off_q           <= 2'b0;
            cnt_q           <= 16'd0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'b0;
            resp_err_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_wen_q   <= 1'b0;
            mem_req_addr_q  <= 32'b0;
            mem_req_wdata_q <= 32'b0;
            mem_req_wmask_q <= 4'b0;
        end else begin
            state_q         <= state_d;
            wen_q           <= wen_d;
            func_q          <= func_d;
            off_q           <= off_d;
            cnt_q           <= cnt_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_wen_q   <= mem_req_wen_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            mem_req_wmask_q <= mem_req_wmask_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_wen   = mem_req_wen_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign mem_req_wmask = mem_req_wmask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random ops against a transaction-level model,
// plus a second instance with a short timeout.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_wen, resp_ready, mem_req_ready, mem_resp_valid, mem_resp_err;
    logic [2:0]  req_func;
    logic [31:0] req_addr, req_wdata, mem_resp_rdata;
    logic        req_ready, resp_valid, resp_err, mem_req_valid, mem_req_wen;
    logic [31:0] resp_rdata, mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;

    logic        req_valid_t, resp_ready_t, mem_req_ready_t, mem_resp_valid_t;
    logic [2:0]  req_func_t;
    logic [31:0] req_addr_t, mem_resp_rdata_t;
    logic        req_ready_t, resp_valid_t, resp_err_t, mem_req_valid_t, mem_req_wen_t;
    logic [31:0] resp_rdata_t, mem_req_addr_t, mem_req_wdata_t;
    logic [3:0]  mem_req_wmask_t;

    int checks = 0;
    int failures = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_func(req_func),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
    );

    load_store_unit #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_t), .req_ready(req_ready_t), .req_wen(1'b0), .req_func(req_func_t),
        .req_addr(req_addr_t), .req_wdata(32'h0),
        .resp_valid(resp_valid_t), .resp_ready(resp_ready_t), .resp_rdata(resp_rdata_t), .resp_err(resp_err_t),
        .mem_req_valid(mem_req_valid_t), .mem_req_ready(mem_req_ready_t), .mem_req_wen(mem_req_wen_t),
        .mem_req_addr(mem_req_addr_t), .mem_req_wdata(mem_req_wdata_t), .mem_req_wmask(mem_req_wmask_t),
        .mem_resp_valid(mem_resp_valid_t), .mem_resp_rdata(mem_resp_rdata_t), .mem_resp_err(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, act, exp);
        end
    endtask

    // Reference model: operation rules in plain arithmetic.
    function automatic logic m_legal(input logic wen, input logic [2:0] func, input logic [31:0] addr);
        int size;
        if (func == 3'd3 || func >= 3'd6) return 1'b0;
        if (wen && func >= 3'd4) return 1'b0;
        size = 1 << func[1:0];
        return (addr % size) == 0;
    endfunction

    function automatic logic [3:0] m_mask(input logic [2:0] func, input logic [31:0] addr);
        int size = 1 << func[1:0];
        return 4'(((1 << size) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] func, input logic [31:0] d);
        case (1 << func[1:0])
            1:       return (d & 32'hFF) * 32'h01010101;
            2:       return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] func, input logic [31:0] addr, input logic [31:0] word);
        int bits = 8 << func[1:0];
        logic [63:0] v;
        v = (64'(word) >> (8 * (addr % 4))) & ((64'd1 << bits) - 1);
        if (func < 3'd4 && v[bits-1]) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_rdata"}, resp_rdata, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_mem_valid"}, mem_req_valid, 0);
        check({tag, "_mem_wen"}, mem_req_wen, 0);
        check({tag, "_mem_addr"}, mem_req_addr, 0);
        check({tag, "_mem_wdata"}, mem_req_wdata, 0);
        check({tag, "_mem_wmask"}, mem_req_wmask, 0);
    endtask

    task automatic do_op(input logic wen, input logic [2:0] func, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] word, input logic berr,
                         input int req_stall, input int resp_dly, input int wb_stall, input logic junk);
        logic ok;
        logic [31:0] exp_rd;
        logic exp_err;
        int n;
        ok      = m_legal(wen, func, addr);
        exp_err = !ok || berr;
        exp_rd  = (!ok || wen || berr) ? 32'h0 : m_load(func, addr, word);
        @(negedge clk);
        check("idle_req_ready", req_ready, 1);
        req_valid = 1'b1; req_wen = wen; req_func = func; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        req_valid = 1'b0; req_wen = $urandom; req_func = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        if (!ok) begin
            check("bad_no_mem", mem_req_valid, 0);
        end else begin
            for (int i = 0; i <= req_stall; i++) begin
                check("mem_valid", mem_req_valid, 1);
                check("mem_wen", mem_req_wen, wen);
                check("mem_addr", mem_req_addr, {addr[31:2], 2'b00});
                check("mem_wmask", mem_req_wmask, wen ? m_mask(func, addr) : 4'h0);
                if (wen) check("mem_wdata", mem_req_wdata, m_wdata(func, wdata));
                check("busy_req_ready", req_ready, 0);
                check("busy_resp_valid", resp_valid, 0);
                if (i == req_stall) break;
                mem_resp_valid = junk; mem_resp_rdata = $urandom; mem_resp_err = junk;
                @(posedge clk); n++;
                @(negedge clk);
                mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
            end
            mem_req_ready = 1'b1;
            @(posedge clk); n++;
            @(negedge clk);
            mem_req_ready = 1'b0;
            check("mem_valid_drop", mem_req_valid, 0);
            repeat (resp_dly) begin
                @(posedge clk); n++;
                @(negedge clk);
                check("wait_resp_valid", resp_valid, 0);
            end
            mem_resp_valid = 1'b1; mem_resp_rdata = word; mem_resp_err = berr;
            @(posedge clk); n++;
            @(negedge clk);
            mem_resp_valid = 1'b0; mem_resp_rdata = $urandom; mem_resp_err = 1'b0;
        end
        check("latency", n + 1, ok ? 3 + req_stall + resp_dly : 1);
        for (int i = 0; i <= wb_stall; i++) begin
            check("resp_valid", resp_valid, 1);
            check("resp_rdata", resp_rdata, exp_rd);
            check("resp_err", resp_err, exp_err);
            check("resp_req_ready", req_ready, 0);
            if (i == wb_stall) break;
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("done_resp_valid", resp_valid, 0);
        check("done_req_ready", req_ready, 1);
    endtask

    task automatic t_run(input logic [2:0] func, input logic [31:0] addr, input logic ready,
                         input logic respond, input logic [31:0] word, input int exp_lat,
                         input logic [31:0] exp_rd, input logic exp_err);
        int n;
        @(negedge clk);
        req_valid_t = 1'b1; req_func_t = func; req_addr_t = addr; mem_req_ready_t = ready;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        req_valid_t = 1'b0;
        while (!resp_valid_t && n < 20) begin
            mem_resp_valid_t = respond && (n == 1);
            mem_resp_rdata_t = word;
            @(posedge clk); n++;
            @(negedge clk);
            mem_resp_valid_t = 1'b0;
        end
        mem_req_ready_t = 1'b0;
        check("to_latency", n + 1, exp_lat);
        check("to_resp_valid", resp_valid_t, 1);
        check("to_rdata", resp_rdata_t, exp_rd);
        check("to_err", resp_err_t, exp_err);
        check("to_mem_valid", mem_req_valid_t, 0);
        mem_resp_valid_t = 1'b1; mem_resp_rdata_t = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        mem_resp_valid_t = 1'b0;
        check("to_late_rdata", resp_rdata_t, exp_rd);
        check("to_late_err", resp_err_t, exp_err);
        resp_ready_t = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready_t = 1'b0;
        mem_resp_valid_t = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_resp_valid_t = 1'b0;
        check("to_idle_resp_valid", resp_valid_t, 0);
        check("to_idle_req_ready", req_ready_t, 1);
        check("to_idle_mem_valid", mem_req_valid_t, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_wen = 0; req_func = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; mem_resp_err = 0;
        req_valid_t = 0; req_func_t = 0; req_addr_t = 0; resp_ready_t = 0;
        mem_req_ready_t = 0; mem_resp_valid_t = 0; mem_resp_rdata_t = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst");
        check("rst_t_req_ready", req_ready_t, 1);
        check("rst_t_resp_valid", resp_valid_t, 0);
        rst = 1'b0;

        do_op(0, 3'b000, 32'h80000003, 32'h0, 32'h80FF1234, 0, 0, 0, 0, 0);
        do_op(1, 3'b001, 32'h80000102, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 0);
        do_op(0, 3'b010, 32'h80000001, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        do_op(0, 3'b101, 32'h80000002, 32'h0, 32'h8001C0DE, 0, 5, 0, 3, 1);
        do_op(0, 3'b010, 32'h00000010, 32'h0, 32'hCAFEF00D, 1, 1, 2, 0, 0);

        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_op(1'($urandom), 3'($urandom), a, $urandom, $urandom, ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
        end

        // Reset while waiting on the bus: the op is dropped silently.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_func = 3'b010; req_addr = 32'h200;
        mem_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("pre_rst_mem_valid", mem_req_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrst");
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h11112222;
        @(posedge clk);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        repeat (2) begin
            check("post_rst_resp_valid", resp_valid, 0);
            check("post_rst_req_ready", req_ready, 1);
            @(posedge clk);
            @(negedge clk);
        end
        do_op(0, 3'b100, 32'h00000301, 32'h0, 32'h0000A500, 0, 0, 0, 0, 0);

        t_run(3'b010, 32'h100, 1'b0, 1'b0, 32'h0, 5, 32'h0, 1'b1);
        t_run(3'b010, 32'h104, 1'b1, 1'b0, 32'h0, 5, 32'h0, 1'b1);
        t_run(3'b101, 32'h102, 1'b1, 1'b1, 32'h87654321, 3, 32'h00008765, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store unit directly downstream of the execute stage; replaces the single-cycle combinational data-memory path with a handshaked bus access.
- Accepts one memory op per transaction from the execute stage and drives a word-addressed data bus with byte write masks.
- Returns aligned, sign- or zero-extended load data (or a store completion) to write-back, with error reporting for misalignment, bad funct, bus error and timeout.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT before forced error; 0 disables; legal 0..65535

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  execute stage presents op
req_ready  out  1  unit can accept op
req_wen  in  1  1=store, 0=load
req_func  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits significant)
resp_valid  out  1  result available to write-back
resp_ready  in  1  write-back accepts result
resp_rdata  out  32  extended load data; 0 for stores/errors
resp_err  out  1  op failed
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts request
mem_req_wen  out  1  bus write
mem_req_addr  out  32  {req_addr[31:2],2'b00}
mem_req_wdata  out  32  lane-replicated store data
mem_req_wmask  out  4  byte enables (0000 for loads)
mem_resp_valid  in  1  bus response, one-cycle pulse
mem_resp_rdata  in  32  bus read word
mem_resp_err  in  1  bus error qualifier

Behaviour:
- One clock domain (clk); synchronous active-high rst; all outputs registered.
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0; timeout counter 0.
- States: IDLE, REQ, WAIT, RESP. req_ready=1 only in IDLE.
- IDLE: on req_valid, latch wen/func/addr/wdata.
  - Illegal op goes straight to RESP with resp_err=1, rdata=0, no bus access. Illegal means: func 011/110/111; store with func[2]=1; h/hu with addr[0]=1; w with addr[1:0]!=0.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1, outputs held stable until mem_req_ready; on handshake go to WAIT, mem_req_valid=0 next cycle.
- WAIT: on mem_resp_valid, capture the result and go to RESP. mem_resp_valid outside WAIT is ignored.
- RESP: resp_valid=1 held, data stable, until resp_ready; then IDLE, resp_valid=0.
- Minimum latency: accept at cycle N, mem_req_valid at N+1 (ready same cycle), mem_resp_valid at N+2, resp_valid at N+3; back-to-back accept at the cycle after resp handshake.
- Store lanes: b -> wdata={4{d[7:0]}}, wmask=0001<<addr[1:0]; h -> {2{d[15:0]}}, 0011<<{addr[1],1'b0}; w -> d, 1111.
- Load extract: s = mem_resp_rdata >> (8*addr[1:0]).
  - b: sign-extend s[7:0]; bu: zero-extend s[7:0].
  - h: sign-extend s[15:0]; hu: zero-extend s[15:0].
  - w: s.
- Store response: rdata=0, err=mem_resp_err.
- Load with mem_resp_err=1: rdata=0, err=1.
- Timeout: counter clears on entering REQ and increments each cycle in REQ/WAIT. If TIMEOUT!=0 and the counter reaches TIMEOUT, go to RESP with err=1, rdata=0, and drop mem_req_valid. A late mem_resp_valid is then ignored.
- rst mid-transaction: abandon the op immediately, return to reset values; no response is generated.

Test Plan:
- Load lb, addr=0x80000003, bus word 0x80FF1234, mem ready immediately, response 1 cycle later -> mem_req_addr=0x80000000, wmask=0000, resp_rdata=0xFFFFFF80, err=0, resp_valid 3 cycles after accept.
- Store sh, addr=0x80000102, wdata=0xDEADBEEF -> mem_req_wdata=0xBEEFBEEF, wmask=1100, wen=1; then resp_rdata=0, err=0.
- lw at 0x80000001 -> no mem_req_valid ever asserted; resp_valid on the cycle after accept with err=1, rdata=0.
- mem_req_ready held low 5 cycles, then resp_ready held low 3 cycles -> mem_req_* and resp_* stable throughout; req_ready=0 until the resp handshake.
- TIMEOUT=4, bus never responds -> resp_err=1 after 4 cycles in REQ/WAIT; later mem_resp_valid ignored; next op completes normally.
- rst asserted in WAIT, then mem_resp_valid arrives -> all outputs at reset values, no resp_valid, req_ready=1.
